// File: rtl/fifo_pkg.sv
// Shared FWFT FIFO definitions: pointer type, read-side state encoding and occupancy helper.
// Both the read- and write-side controllers import this so they agree on pointer wrap encoding.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 4;
  localparam int unsigned FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

  typedef logic [FIFO_PTR_WIDTH-1:0] ptr_t;

  // out_valid is the state bit, so the encoding is fixed rather than left to the tool
  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } rd_state_e;

  // Occupancy between two wrap-bit pointers of width ptr_w, modulo 2**ptr_w.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/fwft_rd_ctrl.sv
// Read-side controller of the FWFT FIFO: owns rd_ptr and prefetches the head word into
// an output register so data falls through with a valid/ready handshake.
module fwft_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] level
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned LVL_W = ADDR_WIDTH + 2;

  rd_state_e state;
  rd_state_e state_nxt;
  logic      mem_ne;
  logic      load;

  assign mem_ne    = (wr_ptr != rd_ptr);
  assign rd_addr   = rd_ptr[ADDR_WIDTH-1:0];
  assign out_valid = (state == VALID);
  assign level     = LVL_W'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PTR_W)) + LVL_W'(out_valid);

  // Flush wins over load; a stalled VALID word keeps everything frozen.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (mem_ne) begin
            load      = 1'b1;
            state_nxt = VALID;
          end
        end
        VALID: begin
          if (out_ready) begin
            if (mem_ne) begin
              load      = 1'b1;
              state_nxt = VALID;
            end else begin
              state_nxt = EMPTY;
            end
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Flush jumps rd_ptr to the sampled wr_ptr, so a same-cycle write survives.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= EMPTY;
      rd_ptr   <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (load) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        out_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_fwft_rd_ctrl.sv
// Directed bench for fwft_rd_ctrl with a behavioural write side and register_file model.
module tb_fwft_rd_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk;
  logic          arst;
  logic [AW:0]   wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW:0]   rd_ptr;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW+1:0] level;

  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem [4];
  logic          full;

  int check_cnt = 0;
  int pass_cnt  = 0;

  fwft_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .arst      (arst),
    .wr_ptr    (wr_ptr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ptr    (rd_ptr),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write side model: full when pointers differ only in the wrap bit
  assign full    = ((wr_ptr ^ rd_ptr) == 3'b100);
  assign rd_data = mem[rd_addr];

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
    end else if (wr_en && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
      wr_ptr <= wr_ptr + 3'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    check_cnt++; if (rd_ptr !== 3'd0) $display("[TB] FAIL reset_rd_ptr: got %0d expected 0", rd_ptr); else pass_cnt++;
    check_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    check_cnt++; if (out_data !== 8'h00) $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); else pass_cnt++;
    check_cnt++; if (level !== 4'd0) $display("[TB] FAIL reset_level: got %0d expected 0", level); else pass_cnt++;
    #1 arst = 1'b0;
  endtask

  task automatic test_fall_through();
    step();
    wr_en = 1'b1; wr_data = 8'hA1; out_ready = 1'b0;
    step();
    wr_en = 1'b0;
    check_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL ft_latency: got out_valid %b expected 0", out_valid); else pass_cnt++;
    step();
    check_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL ft_valid: got %b expected 1", out_valid); else pass_cnt++;
    check_cnt++; if (out_data !== 8'hA1) $display("[TB] FAIL ft_data: got %h expected a1", out_data); else pass_cnt++;
    check_cnt++; if (level !== 4'd1) $display("[TB] FAIL ft_level: got %0d expected 1", level); else pass_cnt++;
    check_cnt++; if (rd_addr !== 2'd1) $display("[TB] FAIL ft_rd_addr: got %0d expected 1", rd_addr); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      step();
      check_cnt++;
      if (out_valid !== 1'b1 || out_data !== 8'hA1 || rd_ptr !== 3'd1)
        $display("[TB] FAIL ft_stall%0d: got v=%b d=%h p=%0d expected v=1 d=a1 p=1", i, out_valid, out_data, rd_ptr);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    #2 arst = 1'b1;
    #1;
    check_cnt++; if (rd_ptr !== 3'd0) $display("[TB] FAIL mid_reset_rd_ptr: got %0d expected 0", rd_ptr); else pass_cnt++;
    check_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_reset_valid: got %b expected 0", out_valid); else pass_cnt++;
    check_cnt++; if (out_data !== 8'h00) $display("[TB] FAIL mid_reset_data: got %h expected 00", out_data); else pass_cnt++;
    #1 arst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp_d;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_en   = (i < 8);
      wr_data = 8'h10 + 8'(i);
      step();
      if (i >= 1 && i <= 8) begin
        exp_d = 8'h10 + 8'(i - 1);
        check_cnt++;
        if (out_valid !== 1'b1 || out_data !== exp_d)
          $display("[TB] FAIL stream_word%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exp_d);
        else pass_cnt++;
        check_cnt++;
        if (rd_ptr !== 3'(i))
          $display("[TB] FAIL stream_rd_ptr%0d: got %0d expected %0d", i, rd_ptr, 3'(i));
        else pass_cnt++;
      end
    end
    wr_en = 1'b0;
    check_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL stream_end_valid: got %b expected 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] exp_d;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    check_cnt++; if (level !== 4'd5) $display("[TB] FAIL fill_level: got %0d expected 5", level); else pass_cnt++;
    check_cnt++; if (rd_ptr !== 3'd1) $display("[TB] FAIL fill_rd_ptr: got %0d expected 1", rd_ptr); else pass_cnt++;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      exp_d = 8'h20 + 8'(j);
      check_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp_d)
        $display("[TB] FAIL drain_word%0d: got v=%b d=%h expected v=1 d=%h", j, out_valid, out_data, exp_d);
      else pass_cnt++;
      step();
    end
    check_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL drain_valid: got %b expected 0", out_valid); else pass_cnt++;
    check_cnt++; if (level !== 4'd0) $display("[TB] FAIL drain_level: got %0d expected 0", level); else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    check_cnt++; if (level !== 4'd3) $display("[TB] FAIL flush_pre_level: got %0d expected 3", level); else pass_cnt++;
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h5C;
    step();
    flush = 1'b0; wr_en = 1'b0;
    check_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b expected 0", out_valid); else pass_cnt++;
    check_cnt++; if (level !== 4'd1) $display("[TB] FAIL flush_level: got %0d expected 1", level); else pass_cnt++;
    step();
    check_cnt++;
    if (out_valid !== 1'b1 || out_data !== 8'h5C)
      $display("[TB] FAIL flush_survivor: got v=%b d=%h expected v=1 d=5c", out_valid, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    check_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_after: got %b expected 0", out_valid); else pass_cnt++;
    check_cnt++; if (level !== 4'd0) $display("[TB] FAIL flush_after_level: got %0d expected 0", level); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_d;
    int sent = 0;
    int got  = 0;
    int cycles = 0;
    while (got < 100 && cycles < 3000) begin
      wr_en     = (sent < 100) && ($urandom_range(0, 1) == 1);
      wr_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      check_cnt++;
      if (level !== 4'(q.size()))
        $display("[TB] FAIL bp_level: got %0d expected %0d", level, q.size());
      else pass_cnt++;
      if (out_valid && out_ready) begin
        check_cnt++;
        if (q.size() == 0) begin
          $display("[TB] FAIL bp_dup: got word %h expected none", out_data);
        end else begin
          exp_d = q.pop_front();
          if (out_data !== exp_d) $display("[TB] FAIL bp_word%0d: got %h expected %h", got, out_data, exp_d);
          else pass_cnt++;
        end
        got++;
      end
      if (wr_en && !full) begin
        q.push_back(wr_data);
        sent++;
      end
      step();
      cycles++;
    end
    wr_en = 1'b0;
    check_cnt++;
    if (got != 100) $display("[TB] FAIL bp_timeout: got %0d words expected 100", got);
    else pass_cnt++;
  endtask

  initial begin
    arst = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    test_reset();
    test_fall_through();
    test_reset_mid();
    test_streaming();
    test_fill_drain();
    test_flush();
    test_backpressure();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
